// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    FIRE      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } arb_state_type;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or after the pointer,
// wrapping modulo NREQ.
module uart_tx_arbiter_rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan from the pointer upward and keep the first hit.
  always_comb begin
    logic         found;
    logic [IW:0]  cand;
    found  = 1'b0;
    cand   = '0;
    idx    = '0;
    onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants the UART transmitter to one message source at a time, round-robin
// between messages, pacing bytes against the transmitter busy flag.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned STALL_TICK = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        grant,
  output logic                   tx_transmit,
  output logic [BYTE_W-1:0]      tx_byte,
  input  logic                   tx_busy,
  output logic                   abort
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(STALL_TICK) + 1;

  arb_state_type     state;
  logic [IW-1:0]     gidx;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     next_ptr;
  logic              last_flag;
  logic [CW-1:0]     stall_cnt;

  logic [NREQ-1:0]   pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  logic              sel_valid;
  logic              sel_last;
  logic [BYTE_W-1:0] sel_data;

  uart_tx_arbiter_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_ptr = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  // Route the granted source's valid/data/last onto a single lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Only the granted source sees ready, and only while a byte is being loaded.
  always_comb begin
    req_ready = '0;
    if (state == LOAD) req_ready[gidx] = req_valid[gidx];
  end

  // Message-level FSM with registered grant, byte, start pulse and abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gidx        <= '0;
      rr_ptr      <= '0;
      last_flag   <= 1'b0;
      stall_cnt   <= '0;
      grant       <= '0;
      tx_transmit <= 1'b0;
      tx_byte     <= '0;
      abort       <= 1'b0;
    end else begin
      tx_transmit <= 1'b0;
      abort       <= 1'b0;
      case (state)
        IDLE: begin
          // A byte may still be shifting out after a reset; wait for it.
          if (!tx_busy && pick_any) begin
            grant     <= pick_onehot;
            gidx      <= pick_idx;
            stall_cnt <= '0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (sel_valid) begin
            tx_byte     <= sel_data;
            last_flag   <= sel_last;
            stall_cnt   <= '0;
            tx_transmit <= 1'b1;
            state       <= FIRE;
          end else if (stall_cnt == CW'(STALL_TICK - 1)) begin
            abort     <= 1'b1;
            grant     <= '0;
            rr_ptr    <= next_ptr;
            stall_cnt <= '0;
            state     <= IDLE;
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        FIRE: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_flag) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among NREQ message sources (score report, game-over notice, key echo, debug dump) so the game can report to the host terminal. Each source streams bytes through a valid/ready port with a `last` marker. The arbiter grants one source for a whole message, round-robin between messages, and paces bytes against the transmitter's busy flag. It sits between the game-side message producers and the `uart` instance in the control path, driving its `transmit`/`tx_byte` inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- STALL_TICK, 1_000_000, cycles a granted source may hold `req_valid` low mid-message before its grant is revoked
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  source i has a byte on req_data[i*8+:8]
- req_data  in  8*NREQ  byte per source
- req_last  in  NREQ  byte on req_data is the final byte of the message
- req_ready  out  NREQ  byte of source i accepted this cycle
- grant  out  NREQ  one-hot owner of the transmitter; 0 when idle
- tx_transmit  out  1  one-cycle start pulse to uart `transmit`
- tx_byte  out  8  byte to uart `tx_byte`; stable from pulse until next load
- tx_busy  in  1  uart `is_transmitting`
- abort  out  1  one-cycle pulse when a grant is revoked by stall timeout

## Operation
- Reset (synchronous, `reset`=1 at a clk edge) clears everything: state IDLE, grant=0, req_ready=0, tx_transmit=0, tx_byte=0, abort=0, rr pointer=0, stall counter=0. Applies mid-message; a byte already shifting in the uart is not cancelled, and the next grant waits for tx_busy=0.
- States: IDLE, LOAD, FIRE, WAIT_BUSY, WAIT_DONE.
- IDLE: when tx_busy=0 and any req_valid, select the first set req_valid at or after rr pointer (wrapping modulo NREQ), register grant, go LOAD. Otherwise stay.
- LOAD: req_ready[g] = req_valid[g] (combinational, granted index only; other ready bits 0). On handshake: capture req_data[g] into tx_byte, capture req_last[g] into last flag, clear stall counter, go FIRE. If req_valid[g]=0: increment stall counter; at STALL_TICK-1 pulse abort, clear grant, rr pointer=g+1 mod NREQ, go IDLE.
- FIRE: tx_transmit=1 for exactly this cycle; go WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy=1, then go WAIT_DONE.
- WAIT_DONE: stay until tx_busy=0. Then if last flag: clear grant, rr pointer=g+1 mod NREQ, go IDLE; else go LOAD.
- Grant never changes mid-message; non-granted sources see req_ready=0 regardless of valid.
- Byte ordering per source preserved; a message is never interleaved with another.
- req_data/req_last of the granted source are sampled only at the handshake cycle.

## Timing
- req_valid rising in IDLE at cycle 0 -> grant at cycle 1, req_ready at cycle 1, tx_transmit at cycle 2.
- Inter-byte: tx_busy falling edge seen at cycle t -> next req_ready at t+1, next tx_transmit at t+2.
- End of message: tx_busy falls at t -> grant=0 at t+1; next requester granted at t+2 earliest.
- Stall counter width $clog2(STALL_TICK)+1; saturates, no wrap.
- abort and tx_transmit are never asserted in the same cycle.
- Outputs grant, tx_byte, tx_transmit, abort registered; req_ready combinational from state, grant and req_valid.

## Structure
- Add `arb_state_type` (IDLE, LOAD, FIRE, WAIT_BUSY, WAIT_DONE) to the shared `enum_type` package beside `state_type`.
- One sub-module: `rr_picker` — combinational round-robin select (inputs request vector, pointer; outputs one-hot and index, plus any-valid).
- Top-level instantiates `uart_tx_arbiter` next to the existing `uart`, replacing the constant-zero transmit tie-offs.

## Test plan
- Single source 0 sends "OK\n" (last on '\n'), model uart busy for 10 cycles -> three tx_transmit pulses with tx_byte 0x4F, 0x4B, 0x0A; grant=0001 throughout; grant=0 one cycle after final busy fall.
- Sources 1 and 3 both valid in IDLE with pointer 0, each sending 2 bytes -> source 1 message fully sent first, then source 3; no interleave; pointer ends at 0 (3+1 mod 4).
- Source 2 drops valid after first byte of 3 with STALL_TICK=16 -> abort pulse 16 cycles into LOAD, grant cleared, pending source 0 granted next.
- Reset asserted during WAIT_DONE with tx_busy=1 -> next cycle all outputs 0, state IDLE; new request not granted until tx_busy=0.
- Back-to-back: source 0 holds valid continuously for 2 single-byte messages while source 1 is valid -> order 0, 1, 0 (round-robin fairness), req_ready never asserted to a non-granted source.
